// File: rtl/hazard_forward_unit.sv
// ============================================================================
// Module  : hazard_forward_unit
// Brief   : EX-stage operand forwarding plus load-use stall FSM with a
//           saturating stall-cycle counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_forward_unit #(
    parameter int AW         = 5,
    parameter int LOAD_STALL = 1,
    parameter int CW         = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] id_rs1,
    input  logic [AW-1:0] id_rs2,
    input  logic          id_use_rs1,
    input  logic          id_use_rs2,
    input  logic [AW-1:0] ex_rs1,
    input  logic [AW-1:0] ex_rs2,
    input  logic [AW-1:0] id_ex_rd,
    input  logic          id_ex_regwrite,
    input  logic          id_ex_memread,
    input  logic [AW-1:0] ex_mem_rd,
    input  logic          ex_mem_regwrite,
    input  logic [AW-1:0] mem_wb_rd,
    input  logic          mem_wb_regwrite,
    input  logic          flush,
    output logic [1:0]    forward_a,
    output logic [1:0]    forward_b,
    output logic          stall,
    output logic          busy,
    output logic [CW-1:0] stall_count
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_next;
    logic        w_hazard;

    // EX/MEM holds the younger result, so it wins over MEM/WB.
    function automatic logic [1:0] fwd_sel(
        input logic [AW-1:0] rs,
        input logic          mem_we,
        input logic [AW-1:0] mem_rd,
        input logic          wb_we,
        input logic [AW-1:0] wb_rd
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (mem_we && (mem_rd != '0) && (mem_rd == rs)) begin
            sel = 2'b10;
        end else if (wb_we && (wb_rd != '0) && (wb_rd == rs)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        forward_a = fwd_sel(ex_rs1, ex_mem_regwrite, ex_mem_rd, mem_wb_regwrite, mem_wb_rd);
        forward_b = fwd_sel(ex_rs2, ex_mem_regwrite, ex_mem_rd, mem_wb_regwrite, mem_wb_rd);
    end

    always_comb begin
        w_hazard = id_ex_memread && id_ex_regwrite && (id_ex_rd != '0) &&
                   ((id_use_rs1 && (id_ex_rd == id_rs1)) ||
                    (id_use_rs2 && (id_ex_rd == id_rs2)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RUN;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        stall        = 1'b0;
        case (r_state)
            RUN: begin
                stall = w_hazard && !flush;
                if (stall && (LOAD_STALL > 1)) begin
                    w_state_next = STALL;
                    w_cnt_next   = 3'(LOAD_STALL - 1);
                end
            end
            STALL: begin
                // A hazard seen here is ignored; it is re-evaluated once back in RUN.
                stall = !flush;
                if (flush || (r_cnt == 3'd1)) begin
                    w_state_next = RUN;
                    w_cnt_next   = 3'd0;
                end else begin
                    w_cnt_next   = r_cnt - 3'd1;
                end
            end
            default: begin
                w_state_next = RUN;
                w_cnt_next   = 3'd0;
            end
        endcase
    end

    assign busy = (r_state == STALL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {CW{1'b1}})) begin
            stall_count <= stall_count + CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
// ============================================================================
// Module  : tb_hazard_forward_unit
// Brief   : Three parameterisations of hazard_forward_unit on shared inputs,
//           checked against a bubble-debt model plus literal scenarios.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hazard_forward_unit;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd;
    logic          id_use_rs1, id_use_rs2, id_ex_regwrite, id_ex_memread;
    logic          ex_mem_regwrite, mem_wb_regwrite, flush;

    logic [1:0]    fa [3];
    logic [1:0]    fb [3];
    logic          stall_v [3];
    logic          busy_v [3];
    logic [15:0]   sc0, sc1;
    logic [2:0]    sc2;

    int checks = 0;
    int errors = 0;

    // Model state: bubbles still owed after the current cycle, and stall tally.
    int rem  [3] = '{0, 0, 0};
    int mcnt [3] = '{0, 0, 0};

    always #10 clk = ~clk;

    hazard_forward_unit #(.AW(AW), .LOAD_STALL(1), .CW(16)) dut0 (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
        .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite), .mem_wb_rd(mem_wb_rd),
        .mem_wb_regwrite(mem_wb_regwrite), .flush(flush), .forward_a(fa[0]), .forward_b(fb[0]),
        .stall(stall_v[0]), .busy(busy_v[0]), .stall_count(sc0));

    hazard_forward_unit #(.AW(AW), .LOAD_STALL(3), .CW(16)) dut1 (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
        .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite), .mem_wb_rd(mem_wb_rd),
        .mem_wb_regwrite(mem_wb_regwrite), .flush(flush), .forward_a(fa[1]), .forward_b(fb[1]),
        .stall(stall_v[1]), .busy(busy_v[1]), .stall_count(sc1));

    hazard_forward_unit #(.AW(AW), .LOAD_STALL(4), .CW(3)) dut2 (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .id_ex_rd(id_ex_rd), .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
        .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite), .mem_wb_rd(mem_wb_rd),
        .mem_wb_regwrite(mem_wb_regwrite), .flush(flush), .forward_a(fa[2]), .forward_b(fb[2]),
        .stall(stall_v[2]), .busy(busy_v[2]), .stall_count(sc2));

    function automatic int ls_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 4;
    endfunction

    function automatic int max_of(input int k);
        return (k == 2) ? 7 : 65535;
    endfunction

    function automatic logic [31:0] sc_of(input int k);
        return (k == 0) ? 32'(sc0) : (k == 1) ? 32'(sc1) : 32'(sc2);
    endfunction

    function automatic logic [1:0] fwd_model(input logic [AW-1:0] rs);
        if (ex_mem_regwrite && ex_mem_rd != 0 && ex_mem_rd == rs) return 2'b10;
        if (mem_wb_regwrite && mem_wb_rd != 0 && mem_wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge, all three DUTs against the model.
    always @(negedge clk) begin
        logic hz;
        logic es;
        hz = id_ex_memread && id_ex_regwrite && (id_ex_rd != 0) &&
             ((id_use_rs1 && id_ex_rd == id_rs1) || (id_use_rs2 && id_ex_rd == id_rs2));
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                rem[k]  = 0;
                mcnt[k] = 0;
            end
            es = (rem[k] > 0) ? !flush : (hz && !flush);
            chk("stall", k, 32'(stall_v[k]), 32'(es));
            chk("busy", k, 32'(busy_v[k]), 32'(rem[k] > 0));
            chk("stall_count", k, sc_of(k), 32'(mcnt[k]));
            chk("forward_a", k, 32'(fa[k]), 32'(fwd_model(ex_rs1)));
            chk("forward_b", k, 32'(fb[k]), 32'(fwd_model(ex_rs2)));
            if (!reset) begin
                if (rem[k] > 0) rem[k] = flush ? 0 : rem[k] - 1;
                else if (es)    rem[k] = ls_of(k) - 1;
                if (es && mcnt[k] < max_of(k)) mcnt[k]++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0;
        id_ex_rd = '0; ex_mem_rd = '0; mem_wb_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_ex_regwrite = 1'b0; id_ex_memread = 1'b0;
        ex_mem_regwrite = 1'b0; mem_wb_regwrite = 1'b0; flush = 1'b0;
    endtask

    task automatic load_use();
        clear_inputs();
        id_ex_memread = 1'b1; id_ex_regwrite = 1'b1; id_ex_rd = 5'd7;
        id_rs2 = 5'd7; id_use_rs2 = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        #3;
        for (int k = 0; k < 3; k++) begin
            chk("reset_count", k, sc_of(k), 32'd0);
            chk("reset_busy", k, 32'(busy_v[k]), 32'd0);
        end
        step(); reset = 1'b0;

        // Forwarding priority.
        step(); ex_mem_rd = 5'd5; mem_wb_rd = 5'd5; ex_mem_regwrite = 1'b1;
        mem_wb_regwrite = 1'b1; ex_rs1 = 5'd5;
        #2 chk("fwd_exmem", 0, 32'(fa[0]), 32'd2);
        step(); ex_mem_regwrite = 1'b0;
        #2 chk("fwd_memwb", 0, 32'(fa[0]), 32'd1);
        step(); ex_mem_regwrite = 1'b1; ex_mem_rd = '0; mem_wb_rd = '0;
        #2 chk("fwd_x0", 0, 32'(fa[0]), 32'd0);
        step(); clear_inputs();

        // Single load-use: one-cycle and three-cycle bubbles.
        step(); load_use();
        #2 chk("lu_c1_stall", 0, 32'(stall_v[0]), 32'd1);
        chk("lu_c1_stall", 1, 32'(stall_v[1]), 32'd1);
        chk("lu_c1_busy", 0, 32'(busy_v[0]), 32'd0);
        chk("lu_c1_busy", 1, 32'(busy_v[1]), 32'd0);
        step(); clear_inputs();
        #2 chk("lu_c2_stall", 0, 32'(stall_v[0]), 32'd0);
        chk("lu_count", 0, sc_of(0), 32'd1);
        chk("lu_c2_stall", 1, 32'(stall_v[1]), 32'd1);
        chk("lu_c2_busy", 1, 32'(busy_v[1]), 32'd1);
        step();
        #2 chk("lu_c3_stall", 1, 32'(stall_v[1]), 32'd1);
        chk("lu_c3_busy", 1, 32'(busy_v[1]), 32'd1);
        step();
        #2 chk("lu_c4_stall", 1, 32'(stall_v[1]), 32'd0);
        chk("lu_c4_busy", 1, 32'(busy_v[1]), 32'd0);
        chk("lu_count", 1, sc_of(1), 32'd3);
        step(); step();

        // Unused source and x0 never stall.
        step(); load_use(); id_use_rs2 = 1'b0; id_rs1 = 5'd7;
        #2 for (int k = 0; k < 3; k++) chk("unused_src", k, 32'(stall_v[k]), 32'd0);
        step(); id_use_rs2 = 1'b1; id_ex_rd = '0; id_rs2 = '0;
        #2 for (int k = 0; k < 3; k++) chk("rd_x0", k, 32'(stall_v[k]), 32'd0);

        // Flush on the second stall cycle of a four-cycle bubble.
        step(); clear_inputs(); reset = 1'b1;
        step(); reset = 1'b0;
        step(); load_use();
        #2 chk("fl_c1_stall", 2, 32'(stall_v[2]), 32'd1);
        step(); clear_inputs(); flush = 1'b1;
        #2 chk("fl_c2_stall", 2, 32'(stall_v[2]), 32'd0);
        chk("fl_c2_busy", 2, 32'(busy_v[2]), 32'd1);
        step(); flush = 1'b0;
        #2 chk("fl_c3_busy", 2, 32'(busy_v[2]), 32'd0);
        chk("fl_c3_stall", 2, 32'(stall_v[2]), 32'd0);
        chk("fl_count", 2, sc_of(2), 32'd1);

        // Saturation, then asynchronous reset mid-stall.
        step(); reset = 1'b1;
        step(); reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(); load_use();
        end
        #2 chk("sat_count", 2, sc_of(2), 32'd7);
        chk("sat_busy", 2, 32'(busy_v[2]), 32'd1);
        #2 reset = 1'b1;
        #1 chk("arst_count", 2, sc_of(2), 32'd0);
        chk("arst_count", 0, sc_of(0), 32'd0);
        for (int k = 0; k < 3; k++) chk("arst_busy", k, 32'(busy_v[k]), 32'd0);
        step(); clear_inputs(); reset = 1'b0;

        // Randomised traffic on a small register set so matches are frequent.
        for (int i = 0; i < 3000; i++) begin
            step();
            id_rs1          = AW'($urandom_range(0, 3));
            id_rs2          = AW'($urandom_range(0, 3));
            ex_rs1          = AW'($urandom_range(0, 3));
            ex_rs2          = AW'($urandom_range(0, 3));
            id_ex_rd        = AW'($urandom_range(0, 3));
            ex_mem_rd       = AW'($urandom_range(0, 3));
            mem_wb_rd       = AW'($urandom_range(0, 3));
            id_use_rs1      = 1'($urandom_range(0, 1));
            id_use_rs2      = 1'($urandom_range(0, 1));
            id_ex_regwrite  = ($urandom_range(0, 3) != 0);
            id_ex_memread   = 1'($urandom_range(0, 1));
            ex_mem_regwrite = 1'($urandom_range(0, 1));
            mem_wb_regwrite = 1'($urandom_range(0, 1));
            flush           = ($urandom_range(0, 7) == 0);
            reset           = ($urandom_range(0, 99) == 0);
        end
        step(); clear_inputs(); reset = 1'b0;
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
